// File: rtl/atmr_vote_monitor.sv
// ---------------------------------------------------------------------------
// atmr_vote_monitor
//
// Clocked majority voter and fault monitor for one ATMR benchmark instance.
// It registers the bitwise majority of the three replica vectors and runs a
// HEALTHY/SUSPECT/FAULTY health machine per replica. It also keeps saturating
// per-replica mismatch counters. When a replica becomes FAULTY, an event
// {id, diff} is pushed into a 4-entry valid/ready queue.
//
// Optional feature macro: ATMR_MON_DEGRADE_EN
//   defined   : when exactly two replicas are FAULTY, z takes the remaining
//               replica's vector. When all three are FAULTY, z = majority.
//   undefined : z is always the majority. Fault bits are status only.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid              replica vectors form a sample this cycle
//   ori_o/mai_o/men_o     replica outputs, replica ids 0/1/2
//   clr_fault             pulse: all replicas HEALTHY, cc cleared, ev_ovf cleared
//   z, z_valid            registered voted vector and its sample strobe
//   unc_err               pulse with z_valid: >=2 replicas disagreed
//   fault[2:0]            per-replica FAULTY flag
//   mis_cnt0/1/2          saturating mismatching-sample counters
//   ev_valid/ev_ready     event queue handshake
//   ev_id, ev_diff        head event: replica id and its diff mask
//   ev_ovf                sticky: an event was dropped on a full queue
// ---------------------------------------------------------------------------
module atmr_vote_monitor #(
  parameter int W      = 10,
  parameter int THRESH = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     ori_o,
  input  logic [W-1:0]     mai_o,
  input  logic [W-1:0]     men_o,
  input  logic             clr_fault,
  output logic [W-1:0]     z,
  output logic             z_valid,
  output logic             unc_err,
  output logic [2:0]       fault,
  output logic [CNT_W-1:0] mis_cnt0,
  output logic [CNT_W-1:0] mis_cnt1,
  output logic [CNT_W-1:0] mis_cnt2,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [1:0]       ev_id,
  output logic [W-1:0]     ev_diff,
  output logic             ev_ovf
);

  localparam logic [1:0] ST_HEALTHY = 2'd0;
  localparam logic [1:0] ST_SUSPECT = 2'd1;
  localparam logic [1:0] ST_FAULTY  = 2'd2;

  logic [2:0][W-1:0]     w_rep;
  logic [2:0][W-1:0]     w_diff;
  logic [2:0][CNT_W-1:0] w_mis_cnt;
  logic [W-1:0]          w_maj;
  logic [W-1:0]          w_z;
  logic [2:0]            w_mism;
  logic [2:0]            w_push;
  logic                  w_unc;

  assign w_rep[0] = ori_o;
  assign w_rep[1] = mai_o;
  assign w_rep[2] = men_o;
  assign w_maj    = (ori_o & mai_o) | (ori_o & men_o) | (mai_o & men_o);
  assign w_unc    = (w_mism[0] & w_mism[1]) | (w_mism[0] & w_mism[2]) | (w_mism[1] & w_mism[2]);

  // Per-replica health machine and mismatch counter
  for (genvar gi = 0; gi < 3; gi++) begin : g_rep
    logic [1:0]       r_state;
    logic [3:0]       r_cc;
    logic [CNT_W-1:0] r_mis_cnt;
    logic [1:0]       w_state_eff;
    logic [1:0]       w_state_next;
    logic [3:0]       w_cc_eff;
    logic [3:0]       w_cc_next;
    logic [4:0]       w_cc_inc;
    logic             w_push_l;

    assign w_diff[gi]    = w_rep[gi] ^ w_maj;
    assign w_mism[gi]    = |w_diff[gi];
    // A clear in the same cycle as a sample is applied first
    assign w_state_eff   = clr_fault ? ST_HEALTHY : r_state;
    assign w_cc_eff      = clr_fault ? 4'd0 : r_cc;
    assign w_cc_inc      = {1'b0, w_cc_eff} + 5'd1;
    assign w_push[gi]    = w_push_l;
    assign fault[gi]     = (r_state == ST_FAULTY);
    assign w_mis_cnt[gi] = r_mis_cnt;

    always_comb begin
      w_state_next = w_state_eff;
      w_cc_next    = w_cc_eff;
      w_push_l     = 1'b0;
      if (in_valid) begin
        case (w_state_eff)
          ST_HEALTHY: begin
            if (w_mism[gi]) begin
              w_state_next = ST_SUSPECT;
              w_cc_next    = 4'd1;
            end
          end
          ST_SUSPECT: begin
            if (!w_mism[gi]) begin
              w_state_next = ST_HEALTHY;
              w_cc_next    = 4'd0;
            end else begin
              w_cc_next = w_cc_inc[3:0];
              if (w_cc_inc == 5'(THRESH)) begin
                w_state_next = ST_FAULTY;
                w_push_l     = 1'b1;
              end
            end
          end
          default: ;  // FAULTY is sticky until clr_fault
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_state   <= ST_HEALTHY;
        r_cc      <= 4'd0;
        r_mis_cnt <= '0;
      end else begin
        r_state <= w_state_next;
        r_cc    <= w_cc_next;
        if (in_valid && w_mism[gi] && (r_mis_cnt != {CNT_W{1'b1}}))
          r_mis_cnt <= r_mis_cnt + CNT_W'(1);
      end
    end
  end

  assign mis_cnt0 = w_mis_cnt[0];
  assign mis_cnt1 = w_mis_cnt[1];
  assign mis_cnt2 = w_mis_cnt[2];

`ifdef ATMR_MON_DEGRADE_EN
  // Degrade selection looks at the fault flags as they stand once any
  // same-cycle clear has been applied
  logic [2:0] w_fault_eff;
  assign w_fault_eff = clr_fault ? 3'b000 : fault;
  always_comb begin
    case (w_fault_eff)
      3'b011:  w_z = men_o;
      3'b101:  w_z = mai_o;
      3'b110:  w_z = ori_o;
      default: w_z = w_maj;
    endcase
  end
`else
  assign w_z = w_maj;
`endif

  logic [W-1:0] r_z;
  logic         r_z_valid;
  logic         r_unc_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_z       <= '0;
      r_z_valid <= 1'b0;
      r_unc_err <= 1'b0;
    end else begin
      r_z_valid <= in_valid;
      r_unc_err <= in_valid & w_unc;
      if (in_valid) r_z <= w_z;
    end
  end

  assign z       = r_z;
  assign z_valid = r_z_valid;
  assign unc_err = r_unc_err;

  // Event queue: 4 entries, up to three pushes per cycle in id order
  logic [1:0]      r_q_id   [4];
  logic [W-1:0]    r_q_diff [4];
  logic [1:0]      r_rd;
  logic [1:0]      r_wr;
  logic [2:0]      r_cnt;
  logic            r_ev_valid;
  logic            r_ev_ovf;
  logic            w_pop;
  logic [2:0]      w_cnt_avail;
  logic [2:0]      w_n;
  logic [1:0]      w_wp;
  logic [2:0]      w_we;
  logic [2:0][1:0] w_waddr;
  logic            w_drop;

  assign w_pop       = r_ev_valid & ev_ready;
  // Space freed by this cycle's pop is usable by this cycle's pushes
  assign w_cnt_avail = r_cnt - {2'b00, w_pop};

  always_comb begin
    w_n     = w_cnt_avail;
    w_wp    = r_wr;
    w_we    = 3'b000;
    w_waddr = '0;
    w_drop  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (w_push[i]) begin
        if (w_n < 3'd4) begin
          w_we[i]    = 1'b1;
          w_waddr[i] = w_wp;
          w_wp       = w_wp + 2'd1;
          w_n        = w_n + 3'd1;
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_q_id[i]   <= 2'd0;
        r_q_diff[i] <= '0;
      end
      r_rd       <= 2'd0;
      r_wr       <= 2'd0;
      r_cnt      <= 3'd0;
      r_ev_valid <= 1'b0;
      r_ev_ovf   <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_we[i]) begin
          r_q_id[w_waddr[i]]   <= 2'(i);
          r_q_diff[w_waddr[i]] <= w_diff[i];
        end
      end
      r_rd       <= r_rd + {1'b0, w_pop};
      r_wr       <= w_wp;
      r_cnt      <= w_n;
      r_ev_valid <= (w_n != 3'd0);
      r_ev_ovf   <= (clr_fault ? 1'b0 : r_ev_ovf) | w_drop;
    end
  end

  assign ev_valid = r_ev_valid;
  assign ev_id    = r_q_id[r_rd];
  assign ev_diff  = r_q_diff[r_rd];
  assign ev_ovf   = r_ev_ovf;

endmodule
